// File: rtl/run_ctrl_pkg.sv
// Shared definitions for the run/halt sequencer: state encodings,
// display source codes and the default halting syscall code.
package run_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_PAUSE = 2'd1,
    ST_STEP  = 2'd2,
    ST_HALT  = 2'd3
  } run_state_e;

  localparam logic [1:0] DISP_SYSCALL = 2'b00;
  localparam logic [1:0] DISP_INSTR   = 2'b01;
  localparam logic [1:0] DISP_BRANCH  = 2'b10;
  localparam logic [1:0] DISP_JUMP    = 2'b11;

  localparam logic [31:0] HALT_CODE_DEFAULT = 32'd10;

endpackage

// File: rtl/run_ctrl_go_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter that
// accepts a level change only after it has held long enough, and a 1-cycle rising-edge pulse.
module go_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 32'd1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic pulse
);

  localparam int unsigned CNT_BITS = (DEBOUNCE_CYCLES < 32'd2) ? 32'd1 : $clog2(DEBOUNCE_CYCLES + 32'd1);
  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(DEBOUNCE_CYCLES - 32'd1);

  logic [1:0]          sync_r;
  logic [CNT_BITS-1:0] cnt_r;
  logic                level_r;
  logic                pulse_r;

  // Synchronize, count consecutive disagreeing cycles, flip the level and pulse on a rise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_r  <= 2'b00;
      cnt_r   <= '0;
      level_r <= 1'b0;
      pulse_r <= 1'b0;
    end else begin
      sync_r  <= {sync_r[0], raw};
      pulse_r <= 1'b0;
      if (sync_r[1] != level_r) begin
        if (cnt_r == CNT_LAST) begin
          level_r <= sync_r[1];
          cnt_r   <= '0;
          pulse_r <= sync_r[1];
        end else begin
          cnt_r <= cnt_r + CNT_BITS'(1);
        end
      end else begin
        // any bounce back to the accepted level restarts the count
        cnt_r <= '0;
      end
    end
  end

  assign level = level_r;
  assign pulse = pulse_r;

endmodule

// File: rtl/run_ctrl.sv
// Run/halt sequencer for the single-cycle MIPS datapath: owns the PC write
// enable, handles syscall halt/print, pause and single-step, and keeps retire statistics.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 32'd1000000,
  parameter int unsigned CNT_W           = 32'd32,
  parameter logic [31:0] HALT_CODE       = HALT_CODE_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic             step_mode,
  input  logic             syscall,
  input  logic [31:0]      v0,
  input  logic [31:0]      a0,
  input  logic             br_taken,
  input  logic             is_jump,
  input  logic [1:0]       disp_sel,
  output logic             pc_enable,
  output logic             halted,
  output logic [31:0]      disp_data,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] jump_cnt
);

  run_state_e       state_r, state_next_s;
  logic [1:0]       step_sync_r;
  logic             step_s;
  logic             go_level_s;
  logic             go_pulse_s;
  logic             halt_req_s;
  logic             pc_enable_s;
  logic             halted_r;
  logic [31:0]      sys_latch_r;
  logic [31:0]      disp_data_r;
  logic [CNT_W-1:0] instr_cnt_r, branch_cnt_r, jump_cnt_r;

  go_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_go_debounce (
    .clk  (clk),
    .rst  (rst),
    .raw  (go),
    .level(go_level_s),
    .pulse(go_pulse_s)
  );

  // Plain 2-flop synchronizer for the step-mode switch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step_sync_r <= 2'b00;
    end else begin
      step_sync_r <= {step_sync_r[0], step_mode};
    end
  end

  assign step_s     = step_sync_r[1];
  assign halt_req_s = syscall && (v0 == HALT_CODE);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; a halting syscall overrides everything.
  always_comb begin
    state_next_s = state_r;
    if (halt_req_s) begin
      state_next_s = ST_HALT;
    end else begin
      case (state_r)
        ST_RUN:   state_next_s = step_s ? ST_STEP : (go_pulse_s ? ST_PAUSE : ST_RUN);
        ST_PAUSE: state_next_s = go_pulse_s ? (step_s ? ST_STEP : ST_RUN) : ST_PAUSE;
        ST_STEP:  state_next_s = step_s ? ST_STEP : ST_RUN;
        ST_HALT:  state_next_s = ST_HALT;
        default:  state_next_s = ST_RUN;
      endcase
    end
  end

  // PC write enable: free-running in RUN, one cycle per go pulse in STEP.
  always_comb begin
    pc_enable_s = 1'b0;
    case (state_r)
      ST_RUN:  pc_enable_s = !halt_req_s;
      ST_STEP: pc_enable_s = go_pulse_s && !halt_req_s;
      default: pc_enable_s = 1'b0;
    endcase
  end

  // Halted flag tracks the state register in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      halted_r <= 1'b0;
    end else begin
      halted_r <= (state_next_s == ST_HALT);
    end
  end

  // Print syscalls latch $a0; pc_enable already excludes the halting case.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sys_latch_r <= 32'd0;
    end else if (pc_enable_s && syscall) begin
      sys_latch_r <= a0;
    end else begin
      sys_latch_r <= sys_latch_r;
    end
  end

  // Saturating retire statistics.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_cnt_r  <= '0;
      branch_cnt_r <= '0;
      jump_cnt_r   <= '0;
    end else if (pc_enable_s) begin
      if (instr_cnt_r != '1) instr_cnt_r <= instr_cnt_r + CNT_W'(1);
      if (br_taken && (branch_cnt_r != '1)) branch_cnt_r <= branch_cnt_r + CNT_W'(1);
      if (is_jump && (jump_cnt_r != '1)) jump_cnt_r <= jump_cnt_r + CNT_W'(1);
    end else begin
      instr_cnt_r  <= instr_cnt_r;
      branch_cnt_r <= branch_cnt_r;
      jump_cnt_r   <= jump_cnt_r;
    end
  end

  // Display word mux; counters are resized to the 32-bit display bus.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      disp_data_r <= 32'd0;
    end else begin
      case (disp_sel)
        DISP_SYSCALL: disp_data_r <= sys_latch_r;
        DISP_INSTR:   disp_data_r <= 32'(instr_cnt_r);
        DISP_BRANCH:  disp_data_r <= 32'(branch_cnt_r);
        DISP_JUMP:    disp_data_r <= 32'(jump_cnt_r);
        default:      disp_data_r <= 32'd0;
      endcase
    end
  end

  assign pc_enable  = pc_enable_s;
  assign halted     = halted_r;
  assign disp_data  = disp_data_r;
  assign instr_cnt  = instr_cnt_r;
  assign branch_cnt = branch_cnt_r;
  assign jump_cnt   = jump_cnt_r;

endmodule

// File: tb/tb_run_ctrl.sv
// Directed self-checking bench for run_ctrl with a short debounce; a second
// instance with 4-bit counters shares the stimulus to exercise saturation.
module tb_run_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        go = 1'b0;
  logic        step_mode = 1'b0;
  logic        syscall = 1'b0;
  logic [31:0] v0 = 32'd0;
  logic [31:0] a0 = 32'd0;
  logic        br_taken = 1'b0;
  logic        is_jump = 1'b0;
  logic [1:0]  disp_sel = 2'b00;

  logic        pc_enable, halted;
  logic [31:0] disp_data, instr_cnt, branch_cnt, jump_cnt;
  logic        s_pc_enable, s_halted;
  logic [31:0] s_disp_data;
  logic [3:0]  s_instr_cnt, s_branch_cnt, s_jump_cnt;

  int checks = 0;
  int failures = 0;
  int exp_i = 0;
  int n;
  int hi;

  always #5 clk = ~clk;

  run_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .go(go), .step_mode(step_mode), .syscall(syscall),
    .v0(v0), .a0(a0), .br_taken(br_taken), .is_jump(is_jump), .disp_sel(disp_sel),
    .pc_enable(pc_enable), .halted(halted), .disp_data(disp_data),
    .instr_cnt(instr_cnt), .branch_cnt(branch_cnt), .jump_cnt(jump_cnt)
  );

  run_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .go(go), .step_mode(step_mode), .syscall(syscall),
    .v0(v0), .a0(a0), .br_taken(br_taken), .is_jump(is_jump), .disp_sel(disp_sel),
    .pc_enable(s_pc_enable), .halted(s_halted), .disp_data(s_disp_data),
    .instr_cnt(s_instr_cnt), .branch_cnt(s_branch_cnt), .jump_cnt(s_jump_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  initial begin
    // reset state
    #12;
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_disp", disp_data, 32'd0);
    check("rst_instr", instr_cnt, 32'd0);
    check("rst_pc_en", {31'd0, pc_enable}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;

    // free run: 10 retires, 3 taken branches, 2 jumps
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      br_taken = (i < 3);
      is_jump  = (i >= 3 && i < 5);
      #1;
      if (pc_enable) hi++;
      tick();
    end
    br_taken = 1'b0;
    is_jump  = 1'b0;
    exp_i = 10;
    check("run_pc_en_cycles", hi, 32'd10);
    check("run_instr", instr_cnt, 32'd10);
    check("run_branch", branch_cnt, 32'd3);
    check("run_jump", jump_cnt, 32'd2);
    disp_sel = 2'b01;
    tick(); exp_i++;
    check("disp_instr", disp_data, 32'd10);

    // syscall print
    disp_sel = 2'b00; syscall = 1'b1; v0 = 32'd1; a0 = 32'h0000_ABCD;
    #1;
    check("sys_pc_en", {31'd0, pc_enable}, 32'd1);
    tick(); exp_i++;
    syscall = 1'b0; a0 = 32'd0;
    tick(); exp_i++;
    check("sys_disp", disp_data, 32'h0000_ABCD);
    check("sys_still_run", {31'd0, pc_enable}, 32'd1);
    check("sys_instr", instr_cnt, exp_i);

    // pause with bounce
    go = 1'b1; tick(); go = 1'b0; tick();
    go = 1'b1; tick(); go = 1'b0; tick();
    exp_i += 4;
    go = 1'b1;
    n = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (!pc_enable) begin
        n = k + 1;
        break;
      end
    end
    check("pause_latency_ok", {31'd0, (n >= 7 && n <= 8)}, 32'd1);
    exp_i += n;
    ticks(3);
    check("pause_pc_en", {31'd0, pc_enable}, 32'd0);
    check("pause_frozen", instr_cnt, exp_i);

    // release, then press again to resume
    go = 1'b0; ticks(8);
    check("pause_hold", {31'd0, pc_enable}, 32'd0);
    go = 1'b1;
    n = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (pc_enable) begin
        n = k + 1;
        break;
      end
    end
    check("resume_seen", {31'd0, (n != 0)}, 32'd1);
    check("resume_instr", instr_cnt, exp_i);
    go = 1'b0; ticks(8); exp_i += 8;

    // single step
    step_mode = 1'b1; ticks(3); exp_i += 3;
    check("step_enter_pc_en", {31'd0, pc_enable}, 32'd0);
    check("step_enter_instr", instr_cnt, exp_i);
    for (int p = 0; p < 3; p++) begin
      go = 1'b1;
      n = 0;
      for (int k = 0; k < 12; k++) begin
        tick();
        if (pc_enable) begin
          n = k + 1;
          break;
        end
      end
      check("step_press_seen", {31'd0, (n != 0)}, 32'd1);
      tick(); exp_i++;
      check("step_one_cycle", {31'd0, pc_enable}, 32'd0);
      go = 1'b0; ticks(8);
    end
    check("step_instr", instr_cnt, exp_i);
    step_mode = 1'b0; ticks(3);
    check("step_exit_pc_en", {31'd0, pc_enable}, 32'd1);
    check("step_exit_instr", instr_cnt, exp_i);
    check("step_branch", branch_cnt, 32'd3);

    // halt
    syscall = 1'b1; v0 = 32'd10;
    #1;
    check("halt_pc_en", {31'd0, pc_enable}, 32'd0);
    tick();
    check("halt_flag", {31'd0, halted}, 32'd1);
    check("halt_instr", instr_cnt, exp_i);
    syscall = 1'b0; v0 = 32'd0;
    go = 1'b1;
    hi = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (pc_enable) hi++;
    end
    go = 1'b0;
    check("halt_ignores_go", hi, 32'd0);
    check("halt_stays", {31'd0, halted}, 32'd1);
    rst = 1'b0;
    #1;
    check("rst2_halted", {31'd0, halted}, 32'd0);
    check("rst2_instr", instr_cnt, 32'd0);
    check("rst2_jump", jump_cnt, 32'd0);
    check("rst2_pc_en", {31'd0, pc_enable}, 32'd1);

    // saturation on the 4-bit instance
    tick();
    rst = 1'b1;
    br_taken = 1'b1;
    ticks(20);
    br_taken = 1'b0;
    check("sat_instr", {28'd0, s_instr_cnt}, 32'h0000_000F);
    check("sat_branch", {28'd0, s_branch_cnt}, 32'h0000_000F);
    check("wide_instr", instr_cnt, 32'd20);
    disp_sel = 2'b01;
    tick();
    check("sat_disp_zext", s_disp_data, 32'h0000_000F);
    check("sat_instr_nowrap", {28'd0, s_instr_cnt}, 32'h0000_000F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
